reg_file: RTL and testbench



---
 rtl/reg_file.sv | 98 +++++++++
 tb/tb_reg_file.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: LEGv8 architectural register file, 32 x 64-bit.
//
// Two combinational read ports feed the source operands and one clocked
// write port takes the write-back result. X31 is the hardwired zero
// register (XZR) and has no storage. X0..X30 hold their own index at
// power-up and again after every synchronous reset.
//
// Ports:
//   clk    in  1   write clock, rising edge
//   we3    in  1   write enable, port 3
//   ra1    in  5   read address, port 1
//   ra2    in  5   read address, port 2
//   wa3    in  5   write address, port 3
//   wd3    in  64  write data, port 3
//   rd1    out 64  read data, port 1 (0 when ra1 == 31)
//   rd2    out 64  read data, port 2 (0 when ra2 == 31)
//   reset  in  1   synchronous active-high reset, reloads index values
//
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a read whose address matches an
//                      enabled write (wa3 != 31) returns wd3 in the same
//                      cycle. When undefined, reads show stored contents.

module reg_file (
  input  logic        clk,
  input  logic        we3,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa3,
  input  logic [63:0] wd3,
  output logic [63:0] rd1,
  output logic [63:0] rd2,
  input  logic        reset
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef logic [63:0] regs_t [0:30];

  // Index pattern used both as the power-up image and as the reset image.
  function automatic regs_t index_values();
    regs_t vals;
    for (int i = 0; i < 31; i++) begin
      vals[i] = 64'(i);
    end
    return vals;
  endfunction

  // The declaration initializer gives the power-up contents without an
  // initial block; FPGA flows map it to the register init values.
  regs_t regs_q = index_values();
  regs_t regs_d;

  logic write_hit;

  // Writes to XZR are dropped here so X31 never needs storage.
  assign write_hit = we3 && (wa3 != ZERO_REG);

  always_comb begin
    regs_d = regs_q;
    if (write_hit) begin
      regs_d[wa3] = wd3;
    end
  end

  // Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= index_values();
    end else begin
      regs_q <= regs_d;
    end
  end

  // The ZERO_REG check comes first so an address of 31 never indexes
  // past the end of the storage array.
  always_comb begin
    rd1 = 64'd0;
    rd2 = 64'd0;
    if (ra1 != ZERO_REG) begin
      rd1 = regs_q[ra1];
    end
    if (ra2 != ZERO_REG) begin
      rd2 = regs_q[ra2];
    end
`ifdef REGFILE_BYPASS_EN
    // Write-through forwarding. Reset is intentionally not considered,
    // so the bypass stays active in a reset cycle.
    if (write_hit && (ra1 == wa3)) begin
      rd1 = wd3;
    end
    if (write_hit && (ra2 == wa3)) begin
      rd2 = wd3;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Covers the power-up image, write/readback, XZR, write-enable gating,
// reset priority and read-during-write with and without forwarding.

module tb_reg_file;

  logic        clk;
  logic        we3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic        reset;

  int compared;
  int mismatched;

  reg_file dut (
    .clk   (clk),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2),
    .reset (reset)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single point of comparison: counts every check and reports misses.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    end
  endtask

  // Drive one clocked operation at the falling edge, let the rising edge
  // take it, then return the controls to idle just after the edge.
  task automatic applyStimulus(input logic rst, input logic we,
                               input logic [4:0] wa, input logic [63:0] wd);
    @(negedge clk);
    reset = rst;
    we3   = we;
    wa3   = wa;
    wd3   = wd;
    @(posedge clk);
    #1;
    reset = 1'b0;
    we3   = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b0;
    we3   = 1'b0;
    ra1   = 5'd0;
    ra2   = 5'd0;
    wa3   = 5'd0;
    wd3   = 64'd0;

    // Power-up image, no reset applied: every register holds its index.
    for (int i = 0; i < 31; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(i);
      #1;
      checkOutput($sformatf("powerup_rd1_x%0d", i), rd1, 64'(i));
      checkOutput($sformatf("powerup_rd2_x%0d", i), rd2, 64'(i));
    end
    ra1 = 5'd31;
    ra2 = 5'd31;
    #1;
    checkOutput("powerup_rd1_xzr", rd1, 64'd0);
    checkOutput("powerup_rd2_xzr", rd2, 64'd0);

    // Write X5 and read it back next to an untouched neighbour.
    applyStimulus(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567);
    ra1 = 5'd5;
    ra2 = 5'd6;
    #1;
    checkOutput("write_x5", rd1, 64'hDEAD_BEEF_0123_4567);
    checkOutput("neighbour_x6", rd2, 64'd6);

    // Write to XZR is discarded and disturbs no stored register.
    applyStimulus(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    ra1 = 5'd31;
    ra2 = 5'd30;
    #1;
    checkOutput("xzr_after_write", rd1, 64'd0);
    checkOutput("x30_after_xzr_write", rd2, 64'd30);

    // we3 low: nothing changes.
    applyStimulus(1'b0, 1'b0, 5'd7, 64'd99);
    ra1 = 5'd7;
    #1;
    checkOutput("we_gated_x7", rd1, 64'd7);

    // Reset priority over a simultaneous write.
    applyStimulus(1'b0, 1'b1, 5'd3, 64'd1000);
    ra1 = 5'd3;
    #1;
    checkOutput("write_x3", rd1, 64'd1000);
    applyStimulus(1'b1, 1'b1, 5'd4, 64'd55);
    ra1 = 5'd3;
    ra2 = 5'd4;
    #1;
    checkOutput("reset_x3", rd1, 64'd3);
    checkOutput("reset_x4_write_lost", rd2, 64'd4);
    ra1 = 5'd5;
    #1;
    checkOutput("reset_x5", rd1, 64'd5);

    // Read-during-write: both ports aimed at the write target X9.
    @(negedge clk);
    ra1 = 5'd9;
    ra2 = 5'd9;
    we3 = 1'b1;
    wa3 = 5'd9;
    wd3 = 64'd123;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("rdw_rd1_before_edge", rd1, 64'd123);
    checkOutput("rdw_rd2_before_edge", rd2, 64'd123);
`else
    checkOutput("rdw_rd1_before_edge", rd1, 64'd9);
    checkOutput("rdw_rd2_before_edge", rd2, 64'd9);
`endif
    @(posedge clk);
    #1;
    we3 = 1'b0;
    #1;
    checkOutput("rdw_rd1_after_edge", rd1, 64'd123);
    checkOutput("rdw_rd2_after_edge", rd2, 64'd123);

    // Distinct ports, distinct registers, after the write settles.
    ra1 = 5'd9;
    ra2 = 5'd10;
    #1;
    checkOutput("dual_port_x9", rd1, 64'd123);
    checkOutput("dual_port_x10", rd2, 64'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
